// File: rtl/topk_result_packer.sv
// topk_result_packer
//   Collects the 32-bit top-k result words of one query and packs them, 16 per
//   beat, into 512-bit beats (lane k = data[32k+31:32k]). Each beat carries
//   the query's session ID, a beat index counting from 0 within the query,
//   and tlast on the final beat of the query.
// Ports:
//   clk, rst_n        kernel clock, asynchronous active-low reset
//   s_session_*       AXI-S session ID for the next query (taken only in IDLE)
//   s_result_*        AXI-S result words, TLAST marks the last word of a query
//   m_pkt_*           AXI-S output {beat_idx, session, tlast, data[511:0]}
//   msg_count         count of tlast beats handed downstream (wraps)
module topk_result_packer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned LANES     = 16,
  parameter int unsigned SESSION_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [SESSION_W-1:0]              s_session_TDATA,
  input  logic                              s_session_TVALID,
  output logic                              s_session_TREADY,
  input  logic [WORD_W-1:0]                 s_result_TDATA,
  input  logic                              s_result_TVALID,
  input  logic                              s_result_TLAST,
  output logic                              s_result_TREADY,
  output logic [16+SESSION_W+WORD_W*LANES:0] m_pkt_TDATA,
  output logic                              m_pkt_TVALID,
  input  logic                              m_pkt_TREADY,
  output logic [31:0]                       msg_count
);

  localparam int unsigned DATA_W     = WORD_W * LANES;
  localparam int unsigned LANE_W     = $clog2(LANES);
  localparam int unsigned SHIFT_W    = $clog2(WORD_W);
  localparam int unsigned IDX_W      = $clog2(DATA_W);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t                 state, state_next;
  logic [SESSION_W-1:0]   session_q;
  logic [DATA_W-1:0]      acc;
  logic [DATA_W-1:0]      acc_wr;
  logic [DATA_W-1:0]      load_data;
  logic [LANE_W-1:0]      lane_cnt;
  logic [15:0]            beat_idx;
  logic                   flush_last;
  logic [IDX_W-1:0]       lane_base;
  logic                   out_free;
  logic                   sess_take;
  logic                   word_take;
  logic                   beat_done;
  logic                   load_out;
  logic                   load_last;

  // Output register can take a new beat if empty or being drained this cycle.
  assign out_free  = !m_pkt_TVALID || m_pkt_TREADY;
  assign lane_base = {lane_cnt, {SHIFT_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next       = state;
    s_session_TREADY = 1'b0;
    s_result_TREADY  = 1'b0;
    sess_take        = 1'b0;
    word_take        = 1'b0;
    beat_done        = 1'b0;
    load_out         = 1'b0;
    load_last        = 1'b0;
    acc_wr           = acc;
    acc_wr[lane_base +: WORD_W] = s_result_TDATA;
    case (state)
      IDLE: begin
        s_session_TREADY = 1'b1;
        if (s_session_TVALID) begin
          sess_take  = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        s_result_TREADY = 1'b1;
        if (s_result_TVALID) begin
          word_take = 1'b1;
          if (lane_cnt == LAST_LANE || s_result_TLAST) begin
            beat_done = 1'b1;
            if (out_free) begin
              load_out   = 1'b1;
              load_last  = s_result_TLAST;
              state_next = s_result_TLAST ? IDLE : ACCUM;
            end else begin
              state_next = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load_out   = 1'b1;
          load_last  = flush_last;
          state_next = flush_last ? IDLE : ACCUM;
        end
      end
      default: state_next = IDLE;
    endcase
    // In FLUSH the completed beat already sits in acc; otherwise it is acc
    // plus the word arriving this cycle.
    load_data = (state == FLUSH) ? acc : acc_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      session_q    <= '0;
      acc          <= '0;
      lane_cnt     <= '0;
      beat_idx     <= '0;
      flush_last   <= 1'b0;
      m_pkt_TDATA  <= '0;
      m_pkt_TVALID <= 1'b0;
      msg_count    <= '0;
    end else begin
      if (sess_take) begin
        session_q <= s_session_TDATA;
        beat_idx  <= '0;
        lane_cnt  <= '0;
        acc       <= '0;
      end
      if (word_take) begin
        if (beat_done) begin
          lane_cnt <= '0;
          if (!load_out) begin
            acc        <= acc_wr;
            flush_last <= s_result_TLAST;
          end
        end else begin
          acc      <= acc_wr;
          lane_cnt <= lane_cnt + 1'b1;
        end
      end
      // acc restarts from zero after each beat so unused lanes read as zero.
      if (load_out) begin
        m_pkt_TDATA <= {beat_idx, session_q, load_last, load_data};
        beat_idx    <= beat_idx + 16'd1;
        acc         <= '0;
      end
      if (load_out)          m_pkt_TVALID <= 1'b1;
      else if (m_pkt_TREADY) m_pkt_TVALID <= 1'b0;
      if (m_pkt_TVALID && m_pkt_TREADY && m_pkt_TDATA[DATA_W])
        msg_count <= msg_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_topk_result_packer.sv
module tb_topk_result_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  s_session_TDATA = '0;
  logic         s_session_TVALID = 1'b0;
  logic         s_session_TREADY;
  logic [31:0]  s_result_TDATA = '0;
  logic         s_result_TVALID = 1'b0;
  logic         s_result_TLAST = 1'b0;
  logic         s_result_TREADY;
  logic [544:0] m_pkt_TDATA;
  logic         m_pkt_TVALID;
  logic         m_pkt_TREADY;
  logic [31:0]  msg_count;

  topk_result_packer #(.WORD_W(32), .LANES(16), .SESSION_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_session_TDATA(s_session_TDATA), .s_session_TVALID(s_session_TVALID),
    .s_session_TREADY(s_session_TREADY),
    .s_result_TDATA(s_result_TDATA), .s_result_TVALID(s_result_TVALID),
    .s_result_TLAST(s_result_TLAST), .s_result_TREADY(s_result_TREADY),
    .m_pkt_TDATA(m_pkt_TDATA), .m_pkt_TVALID(m_pkt_TVALID),
    .m_pkt_TREADY(m_pkt_TREADY), .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [544:0] exp_q[$];
  logic [31:0]  wq[$];
  longint       acc_cyc[$];
  int unsigned  exp_msgs = 0;
  logic [544:0] last_beat = '0;
  int           beats_seen = 0;
  int           words_acc = 0;
  int           rdy_mode = 0;
  bit           gap_en = 1'b0;
  longint       cyc = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [544:0] act, logic [544:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void flag(string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endfunction

  // Reference: a query of n words becomes ceil(n/16) beats; beat b holds
  // words 16b..16b+15 in lanes 0..15 (missing words zero), index b, and
  // tlast only on the final beat.
  function automatic void model_query(logic [15:0] sess);
    int n;
    int nb;
    logic [511:0] d;
    n  = wq.size();
    nb = (n + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int k = 0; k < 16; k++)
        if (16 * b + k < n) d[32*k +: 32] = wq[16*b+k];
      exp_q.push_back({16'(b), sess, (b == nb - 1), d});
    end
  endfunction

  // Output ready pattern: 0 always ready, 1 mostly ready, 2 stalled.
  initial begin
    m_pkt_TREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_pkt_TREADY = 1'b1;
        1:       m_pkt_TREADY = ($urandom_range(0, 7) != 0);
        default: m_pkt_TREADY = 1'b0;
      endcase
    end
  end

  // Compare process: every cycle with rst_n high.
  logic         prev_hold = 1'b0;
  logic [544:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", m_pkt_TVALID, 1'b1);
        chk("hold_data", m_pkt_TDATA, prev_data);
      end
      chk("msg_count", msg_count, exp_msgs);
      if (m_pkt_TVALID && m_pkt_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", m_pkt_TDATA);
        end else begin
          chk("beat", m_pkt_TDATA, exp_q.pop_front());
        end
        last_beat = m_pkt_TDATA;
        beats_seen++;
        if (m_pkt_TDATA[512]) exp_msgs++;
      end
      prev_hold = m_pkt_TVALID && !m_pkt_TREADY;
      prev_data = m_pkt_TDATA;
    end
  end

  // Drivers are entered just after a rising edge; acceptance is sampled on
  // the falling edge before the edge that performs the transfer.
  task automatic send_session(input logic [15:0] s);
    int  w;
    logic ok;
    w = 0;
    if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_session_TDATA  = s;
    s_session_TVALID = 1'b1;
    do begin
      @(negedge clk); ok = s_session_TREADY;
      @(posedge clk); #1;
      w++;
    end while (!ok && w < 5000);
    s_session_TVALID = 1'b0;
    if (!ok) flag("session_wait");
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int  w;
    logic ok;
    w = 0;
    if (gap_en && $urandom_range(0, 15) == 0) begin @(posedge clk); #1; end
    s_result_TDATA  = d;
    s_result_TLAST  = last;
    s_result_TVALID = 1'b1;
    do begin
      @(negedge clk); ok = s_result_TREADY;
      @(posedge clk); #1;
      w++;
    end while (!ok && w < 5000);
    s_result_TVALID = 1'b0;
    s_result_TLAST  = 1'b0;
    if (!ok) flag("word_wait");
    else begin
      words_acc++;
      acc_cyc.push_back(cyc);
    end
  endtask

  task automatic run_query(input logic [15:0] sess);
    model_query(sess);
    acc_cyc.delete();
    fork
      send_session(sess);
      begin
        for (int i = 0; i < wq.size(); i++) send_word(wq[i], i == wq.size() - 1);
      end
    join
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) flag("drain");
  endtask

  initial begin
    int w0;
    int exp_beats;
    int b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sess_ready", s_session_TREADY, 1'b1);
    chk("rst_res_ready", s_result_TREADY, 1'b0);
    chk("rst_valid", m_pkt_TVALID, 1'b0);
    chk("rst_data", m_pkt_TDATA, '0);
    chk("rst_msg_count", msg_count, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single full beat.
    rdy_mode = 0;
    @(posedge clk); #1;
    wq.delete();
    for (int i = 1; i <= 16; i++) wq.push_back(32'(i));
    run_query(16'h0007);
    chk("t1_latency_valid", m_pkt_TVALID, 1'b1);
    drain();
    chk("t1_lane0", last_beat[31:0], 32'h1);
    chk("t1_lane15", last_beat[511:480], 32'h10);
    chk("t1_tlast", last_beat[512], 1'b1);
    chk("t1_meta", last_beat[544:513], 32'h0000_0007);
    chk("t1_msg_count", msg_count, 32'd1);

    // 35 words, no stalls: consecutive acceptance.
    wq.delete();
    for (int i = 1; i <= 35; i++) wq.push_back(32'h5000_0000 + 32'(i));
    run_query(16'h0123);
    chk("t2_consecutive", 32'(acc_cyc[34] - acc_cyc[0]), 32'd34);
    drain();
    chk("t2_last_beat", last_beat,
        {16'd2, 16'h0123, 1'b1, 416'h0, 32'h5000_0023, 32'h5000_0022, 32'h5000_0021});

    // Same with the output stalled for 40 cycles.
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    w0 = words_acc;
    fork
      run_query(16'h0123);
      begin
        repeat (40) begin @(posedge clk); #1; end
        chk("t3_words_in_stall", 32'(words_acc - w0), 32'd32);
        chk("t3_res_ready_low", s_result_TREADY, 1'b0);
        rdy_mode = 0;
      end
    join
    drain();
    chk("t3_msg_count", msg_count, 32'd3);

    // Two one-word queries.
    wq.delete();
    wq.push_back(32'hDEAD_BEEF);
    run_query(16'hAAAA);
    wq.delete();
    wq.push_back(32'hCAFE_F00D);
    run_query(16'hBBBB);
    drain();
    chk("t4_second_beat", last_beat, {16'd0, 16'hBBBB, 1'b1, 480'h0, 32'hCAFE_F00D});
    chk("t4_msg_count", msg_count, 32'd5);

    // Reset mid-query with a beat held in the output register.
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fork
      send_session(16'h0055);
      begin
        for (int i = 0; i < 20; i++) send_word(32'h7700_0000 + 32'(i), 1'b0);
      end
    join
    chk("t5_held_valid", m_pkt_TVALID, 1'b1);
    #2;
    rst_n    = 1'b0;
    exp_msgs = 0;
    #1;
    chk("t5_async_valid", m_pkt_TVALID, 1'b0);
    chk("t5_async_data", m_pkt_TDATA, '0);
    chk("t5_async_msg", msg_count, '0);
    chk("t5_async_sess_ready", s_session_TREADY, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(32'h1000 + 32'(i));
    run_query(16'h0001);
    drain();
    chk("t5_clean_meta", last_beat[544:513], 32'h0000_0001);
    chk("t5_msg_count", msg_count, 32'd1);

    // Randomised queries with input gaps and output back-pressure.
    gap_en    = 1'b1;
    rdy_mode  = 1;
    exp_beats = 0;
    b0        = beats_seen;
    for (int q = 0; q < 1000; q++) begin
      int len;
      len = $urandom_range(1, 100);
      exp_beats += (len + 15) / 16;
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back($urandom);
      run_query(16'($urandom));
    end
    drain();
    chk("rand_beats", 32'(beats_seen - b0), 32'(exp_beats));
    chk("rand_msg_count", msg_count, 32'd1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
